store_write_buffer: RTL and testbench
=====================================

Name: store_write_buffer

Overview:
- FIFO of committed stores between the MEM stage and main memory.
- Lets sw retire from MEM without waiting out the multi-cycle memory write latency.
- Drains the oldest entry to memory under control of the hazard unit's stall_buf. Raises mem_write_buf so the hazard unit can count memory cycles.
- Provides store-to-load forwarding so a lw in MEM sees pending buffered stores.

Parameters:
DEPTH, 4, number of entries (power of two, >=2)
ADDR_W, 32, byte address width
DATA_W, 32, store data width

Ports:
clk  in  1  single clock
reset  in  1  asynchronous, active-low reset
push  in  1  MEM-stage store commits this cycle (MemWriteM & ~StallM)
push_addr  in  ADDR_W  store byte address (ALUOutM)
push_data  in  DATA_W  store data (WriteDataM)
stall_buf  in  1  from hazard unit; 1 = head write still in progress
ld_addr  in  ADDR_W  load address in MEM, for forwarding lookup
ld_hit  out  1  some valid entry matches ld_addr (word compare)
ld_data  out  DATA_W  data of youngest matching entry; 0 when ld_hit=0
mem_write_buf  out  1  buffer non-empty; head presented to memory (MemWriteBuf)
mem_we  out  1  memory write enable (equals mem_write_buf)
mem_addr  out  ADDR_W  head entry address
mem_wdata  out  DATA_W  head entry data
full  out  1  count == DEPTH
empty  out  1  count == 0
count  out  $clog2(DEPTH)+1  occupied entries
overflow  out  1  sticky: push was dropped while full

Behaviour:
- Reset (reset=0, asynchronous):
  - Pointers, count, valid bits and overflow are cleared.
  - Outputs: empty=1, full=0, count=0, mem_write_buf=0, mem_we=0, ld_hit=0, ld_data=0.
  - mem_addr and mem_wdata are 0, because entry storage is cleared.
- Storage: DEPTH entries of {valid, addr, data}; head pointer (rd_ptr) and tail pointer (wr_ptr) wrap modulo DEPTH.
- Push: on a clk edge with push=1 and (not full, or pop in the same cycle), write the entry at wr_ptr and advance wr_ptr.
- Pop condition: pop = !empty & !stall_buf.
  - On the clk edge with pop=1, invalidate the entry at rd_ptr and advance rd_ptr.
  - The head is presented combinationally from registered state.
  - Memory sees a stable address and data for every cycle that stall_buf=1; the last write cycle is the one with stall_buf=0.
- Count: count_next = count + push_accepted - pop.
  - Simultaneous push and pop leaves count unchanged.
  - This is legal when full: the pop frees a slot that the push fills.
- Full with push and no pop: the push is dropped, state is unchanged and overflow is set.
  - overflow stays set until reset. The hazard unit must prevent this case; the sticky flag is for assertion only.
- Empty with stall_buf=1: no effect.
- Forwarding:
  - Compare ld_addr[ADDR_W-1:2] against every valid entry's addr[ADDR_W-1:2].
  - On multiple matches, select the youngest entry, i.e. the one closest to wr_ptr walking backward.
  - Lookup is purely combinational on registered entries. A push in the same cycle is not visible until the next cycle.
  - An entry popped this cycle is still visible this cycle.
- No flush input: buffered stores are architecturally committed and always drain.
- Reset mid-drain: all entries are discarded immediately; mem_we falls asynchronously.

Decomposition:
- Shared package (mips_pkg):
  - ADDR_W/DATA_W defaults
  - word-offset constant (2)
  - the buffer entry struct {valid, addr, data}, for reuse by the data cache controller
- Natural sub-module: store_fwd_match, a combinational youngest-match priority selector over the entry array given rd_ptr/wr_ptr.

Test Plan:
- Reset with reset=0 mid-run -> empty=1, count=0, mem_we=0, overflow=0, ld_hit=0 immediately, without waiting for a clk edge.
- Push addr=0x100 data=0xAA, stall_buf=1 for 3 cycles then 0 -> mem_we=1, mem_addr=0x100 and mem_wdata=0xAA for 4 cycles; empty=1 on the following cycle.
- Push 4 stores with stall_buf held 1 -> full=1, count=4. A 5th push -> dropped, overflow=1, count stays 4. Then push with stall_buf=0 -> count stays 4 and the new entry lands at the wrapped slot.
- Push 0x200/0x11 then 0x200/0x22, ld_addr=0x202 -> ld_hit=1, ld_data=0x22 (youngest). ld_addr=0x204 -> ld_hit=0, ld_data=0.
- Push 0x300/0x33 and set ld_addr=0x300 in the same cycle -> ld_hit=0 that cycle, ld_hit=1 with ld_data=0x33 the next cycle.
- Fill, drain and refill 3x DEPTH entries with incrementing data -> memory receives every entry in push order, with no skips or duplicates across pointer wrap.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared widths, word offset and store buffer entry type
package mips_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int WORD_OFF   = 2;

    typedef struct packed {
        logic                  valid;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/store_fwd_match.sv
// rtl/store_fwd_match.sv - youngest-match selector over the store buffer entries
module store_fwd_match #(
    parameter int DEPTH  = 4,
    parameter int WORD_W = 30,
    parameter int DATA_W = 32
) (
    input  logic [DEPTH-1:0]         valid_i,
    input  logic [WORD_W-1:0]        word_i [DEPTH],
    input  logic [DATA_W-1:0]        data_i [DEPTH],
    input  logic [$clog2(DEPTH)-1:0] wr_ptr_i,
    input  logic [WORD_W-1:0]        ld_word_i,
    output logic                     hit_o,
    output logic [DATA_W-1:0]        data_o
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] idx;

    // Walk from the oldest slot toward wr_ptr-1 so the youngest match overwrites earlier ones.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            idx = wr_ptr_i - PW'(k);
            if (valid_i[idx] && (word_i[idx] == ld_word_i)) begin
                hit_o  = 1'b1;
                data_o = data_i[idx];
            end
        end
    end

endmodule

// File: rtl/store_write_buffer.sv
// rtl/store_write_buffer.sv - committed-store FIFO draining to memory with load forwarding
module store_write_buffer
    import mips_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [ADDR_W-1:0]        push_addr,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     stall_buf,
    input  logic [ADDR_W-1:0]        ld_addr,
    output logic                     ld_hit,
    output logic [DATA_W-1:0]        ld_data,
    output logic                     mem_write_buf,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int PW     = $clog2(DEPTH);
    localparam int CW     = PW + 1;
    localparam int WORD_W = ADDR_W - WORD_OFF;

    logic [DEPTH-1:0]  valid_q;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [WORD_W-1:0] word_q [DEPTH];
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              pop, push_acc;
    logic [WORD_OFF-1:0] unused_ld_lsb;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign overflow = overflow_q;

    assign pop      = !empty && !stall_buf;
    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign push_acc = push && (!full || pop);

    always_comb begin
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        wr_ptr_d   = wr_ptr_q + PW'(push_acc);
        count_d    = count_q + CW'(push_acc) - CW'(pop);
        overflow_d = overflow_q || (push && full && !pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            if (pop) begin
                valid_q[rd_ptr_q] <= 1'b0;
            end
            if (push_acc) begin
                valid_q[wr_ptr_q] <= 1'b1;
                addr_q[wr_ptr_q]  <= push_addr;
                data_q[wr_ptr_q]  <= push_data;
            end
        end
    end

    assign mem_write_buf = !empty;
    assign mem_we        = !empty;
    assign mem_addr      = addr_q[rd_ptr_q];
    assign mem_wdata     = data_q[rd_ptr_q];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            word_q[i] = addr_q[i][ADDR_W-1:WORD_OFF];
        end
    end

    assign unused_ld_lsb = ld_addr[WORD_OFF-1:0];

    store_fwd_match #(
        .DEPTH  (DEPTH),
        .WORD_W (WORD_W),
        .DATA_W (DATA_W)
    ) u_fwd (
        .valid_i   (valid_q),
        .word_i    (word_q),
        .data_i    (data_q),
        .wr_ptr_i  (wr_ptr_q),
        .ld_word_i (ld_addr[ADDR_W-1:WORD_OFF]),
        .hit_o     (ld_hit),
        .data_o    (ld_data)
    );

endmodule

// File: tb/tb_store_write_buffer.sv
// tb/tb_store_write_buffer.sv - randomized self-checking bench for store_write_buffer
module tb_store_write_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        push = 1'b0;
    logic [31:0] push_addr = '0;
    logic [31:0] push_data = '0;
    logic        stall_buf = 1'b0;
    logic [31:0] ld_addr = '0;
    logic        ld_hit, mem_write_buf, mem_we, full, empty, overflow;
    logic [31:0] ld_data, mem_addr, mem_wdata;
    logic [2:0]  count;

    int n_pass = 0;
    int n_total = 0;

    logic [31:0] m_addr [$];
    logic [31:0] m_data [$];
    bit          m_ovf;
    logic [31:0] log_addr [$];
    logic [31:0] log_data [$];

    store_write_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .push(push), .push_addr(push_addr),
        .push_data(push_data), .stall_buf(stall_buf), .ld_addr(ld_addr),
        .ld_hit(ld_hit), .ld_data(ld_data), .mem_write_buf(mem_write_buf),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .full(full), .empty(empty), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Reference: youngest queued store whose word address equals the load's.
    function automatic void m_fwd(input logic [31:0] a, output bit hit, output logic [31:0] d);
        hit = 0;
        d = '0;
        for (int i = m_addr.size() - 1; i >= 0; i--) begin
            if (m_addr[i][31:2] == a[31:2]) begin
                hit = 1;
                d = m_data[i];
                break;
            end
        end
    endfunction

    task automatic tick();
        bit m_pop, m_full, m_acc;
        m_pop  = (m_addr.size() != 0) && !stall_buf;
        m_full = (m_addr.size() == DEPTH);
        m_acc  = push && (!m_full || m_pop);
        if (mem_we && !stall_buf) begin
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_wdata);
        end
        @(posedge clk);
        if (push && m_full && !m_pop) m_ovf = 1;
        if (m_pop) begin
            void'(m_addr.pop_front());
            void'(m_data.pop_front());
        end
        if (m_acc) begin
            m_addr.push_back(push_addr);
            m_data.push_back(push_data);
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        push = 1'b0;
        stall_buf = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        m_addr.delete();
        m_data.delete();
        m_ovf = 0;
        #1;
    endtask

    task automatic drain_logged();
        push = 1'b0;
        stall_buf = 1'b0;
        for (int c = 0; c < 20 && !empty; c++) tick();
        #1;
        n_total++;
        if (empty !== 1'b1) $display("FAIL drain_timeout: empty=%b required 1", empty);
        else n_pass++;
    endtask

    task automatic test_reset();
        apply_reset();
        n_total++;
        if ({empty, full, count, mem_write_buf, mem_we, overflow, ld_hit} !== {1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0})
            $display("FAIL reset_flags: e=%b f=%b c=%0d mwb=%b we=%b ov=%b hit=%b required 1 0 0 0 0 0 0",
                     empty, full, count, mem_write_buf, mem_we, overflow, ld_hit);
        else n_pass++;
        n_total++;
        if ({mem_addr, mem_wdata, ld_data} !== 96'd0)
            $display("FAIL reset_data: addr=%h wdata=%h ld_data=%h required 0", mem_addr, mem_wdata, ld_data);
        else n_pass++;
    endtask

    task automatic test_single_drain();
        apply_reset();
        push = 1'b1; push_addr = 32'h100; push_data = 32'hAA; stall_buf = 1'b1;
        tick();
        push = 1'b0;
        for (int c = 0; c < 4; c++) begin
            stall_buf = (c < 3);
            #1;
            n_total++;
            if ({mem_we, mem_write_buf, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h100, 32'hAA})
                $display("FAIL single_hold[%0d]: we=%b addr=%h data=%h required 1 100 aa", c, mem_we, mem_addr, mem_wdata);
            else n_pass++;
            tick();
        end
        #1;
        n_total++;
        if ({empty, mem_we, count} !== {1'b1, 1'b0, 3'd0})
            $display("FAIL single_empty: empty=%b we=%b count=%0d required 1 0 0", empty, mem_we, count);
        else n_pass++;
    endtask

    task automatic test_overflow_wrap();
        logic [31:0] exp_a [$];
        apply_reset();
        stall_buf = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push = 1'b1; push_addr = 32'h400 + 4 * i; push_data = 32'h40 + i;
            if (i == 4) begin
                #1;
                n_total++;
                if ({full, count, overflow} !== {1'b1, 3'd4, 1'b0})
                    $display("FAIL full_flags: full=%b count=%0d ov=%b required 1 4 0", full, count, overflow);
                else n_pass++;
            end
            tick();
        end
        push = 1'b0;
        #1;
        n_total++;
        if ({full, count, overflow} !== {1'b1, 3'd4, 1'b1})
            $display("FAIL overflow_flags: full=%b count=%0d ov=%b required 1 4 1", full, count, overflow);
        else n_pass++;
        push = 1'b1; push_addr = 32'h500; push_data = 32'h55; stall_buf = 1'b0;
        log_addr.delete(); log_data.delete();
        tick();
        push = 1'b0;
        #1;
        n_total++;
        if ({full, count} !== {1'b1, 3'd4})
            $display("FAIL push_pop_full: full=%b count=%0d required 1 4", full, count);
        else n_pass++;
        drain_logged();
        exp_a = '{32'h400, 32'h404, 32'h408, 32'h40C, 32'h500};
        n_total++;
        if (log_addr.size() != 5) $display("FAIL wrap_len: got %0d required 5", log_addr.size());
        else n_pass++;
        for (int i = 0; i < 5 && i < log_addr.size(); i++) begin
            n_total++;
            if ({log_addr[i], log_data[i]} !== {exp_a[i], (i == 4) ? 32'h55 : 32'h40 + i})
                $display("FAIL wrap_order[%0d]: got %h/%h required %h/%h", i, log_addr[i], log_data[i],
                         exp_a[i], (i == 4) ? 32'h55 : 32'h40 + i);
            else n_pass++;
        end
        n_total++;
        if (overflow !== 1'b1) $display("FAIL overflow_sticky: got %b required 1", overflow);
        else n_pass++;
    endtask

    task automatic test_forwarding();
        apply_reset();
        stall_buf = 1'b1;
        push = 1'b1; push_addr = 32'h200; push_data = 32'h11; tick();
        push_data = 32'h22; tick();
        push = 1'b0;
        ld_addr = 32'h202;
        #1;
        n_total++;
        if ({ld_hit, ld_data} !== {1'b1, 32'h22})
            $display("FAIL fwd_youngest: hit=%b data=%h required 1 22", ld_hit, ld_data);
        else n_pass++;
        ld_addr = 32'h204;
        #1;
        n_total++;
        if ({ld_hit, ld_data} !== {1'b0, 32'h0})
            $display("FAIL fwd_miss: hit=%b data=%h required 0 0", ld_hit, ld_data);
        else n_pass++;
        push = 1'b1; push_addr = 32'h300; push_data = 32'h33; ld_addr = 32'h300;
        #1;
        n_total++;
        if ({ld_hit, ld_data} !== {1'b0, 32'h0})
            $display("FAIL fwd_same_cycle: hit=%b data=%h required 0 0", ld_hit, ld_data);
        else n_pass++;
        tick();
        push = 1'b0;
        #1;
        n_total++;
        if ({ld_hit, ld_data} !== {1'b1, 32'h33})
            $display("FAIL fwd_next_cycle: hit=%b data=%h required 1 33", ld_hit, ld_data);
        else n_pass++;
    endtask

    task automatic test_fill_drain_refill();
        apply_reset();
        log_addr.delete(); log_data.delete();
        for (int r = 0; r < 3; r++) begin
            stall_buf = 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                push = 1'b1; push_addr = 32'h1000 + 4 * (r * DEPTH + i); push_data = r * DEPTH + i + 1;
                tick();
            end
            drain_logged();
        end
        n_total++;
        if (log_addr.size() != 3 * DEPTH) $display("FAIL refill_len: got %0d required %0d", log_addr.size(), 3 * DEPTH);
        else n_pass++;
        for (int i = 0; i < 3 * DEPTH && i < log_addr.size(); i++) begin
            n_total++;
            if ({log_addr[i], log_data[i]} !== {32'h1000 + 4 * i, 32'(i + 1)})
                $display("FAIL refill_order[%0d]: got %h/%h required %h/%h", i, log_addr[i], log_data[i],
                         32'h1000 + 4 * i, i + 1);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        bit          e_hit;
        logic [31:0] e_ld;
        apply_reset();
        for (int c = 0; c < 300; c++) begin
            push      = ($urandom_range(0, 99) < 55);
            stall_buf = ($urandom_range(0, 99) < 60);
            push_addr = 32'h2000 + 4 * $urandom_range(0, 5) + $urandom_range(0, 3);
            push_data = $urandom;
            ld_addr   = 32'h2000 + 4 * $urandom_range(0, 6) + $urandom_range(0, 3);
            #1;
            m_fwd(ld_addr, e_hit, e_ld);
            n_total++;
            if ({count, empty, full, mem_we, overflow, ld_hit, ld_data} !==
                {3'(m_addr.size()), m_addr.size() == 0, m_addr.size() == DEPTH, m_addr.size() != 0, m_ovf, e_hit, e_ld})
                $display("FAIL rand_state[%0d]: c=%0d e=%b f=%b we=%b ov=%b hit=%b d=%h required c=%0d ov=%b hit=%b d=%h",
                         c, count, empty, full, mem_we, overflow, ld_hit, ld_data, m_addr.size(), m_ovf, e_hit, e_ld);
            else n_pass++;
            if (m_addr.size() != 0) begin
                n_total++;
                if ({mem_addr, mem_wdata} !== {m_addr[0], m_data[0]})
                    $display("FAIL rand_head[%0d]: got %h/%h required %h/%h", c, mem_addr, mem_wdata, m_addr[0], m_data[0]);
                else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        stall_buf = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push = 1'b1; push_addr = 32'h600 + 4 * i; push_data = i;
            tick();
        end
        push = 1'b0;
        ld_addr = 32'h600;
        #1;
        reset = 1'b0;
        #1;
        n_total++;
        if ({empty, count, mem_we, overflow, ld_hit} !== {1'b1, 3'd0, 1'b0, 1'b0, 1'b0})
            $display("FAIL async_reset: e=%b c=%0d we=%b ov=%b hit=%b required 1 0 0 0 0",
                     empty, count, mem_we, overflow, ld_hit);
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        m_addr.delete(); m_data.delete(); m_ovf = 0;
    endtask

    initial begin
        test_reset();
        test_single_drain();
        test_overflow_wrap();
        test_forwarding();
        test_fill_drain_refill();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
